plru_way_select: RTL and testbench
==================================

PLRU_WAY_SELECT -- requirements
Module: plru_way_select

Interface
REQ-001 SHALL have parameter WAYS, default 8, number of ways; power of two, >= 2.
REQ-002 SHALL have parameter SETS, default 16, number of sets; power of two, >= 2.
REQ-003 SHALL have parameter TAG_W, default 12, tag width in bits.
REQ-004 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port req_valid  input  1  lookup request present.
REQ-007 SHALL have port req_ready  output  1  block can accept a request this cycle.
REQ-008 SHALL have port req_set  input  $clog2(SETS)  set index.
REQ-009 SHALL have port req_tag  input  TAG_W  lookup tag.
REQ-010 SHALL have port way_tags  input  WAYS*TAG_W  stored tags; way i at bits [i*TAG_W +: TAG_W].
REQ-011 SHALL have port way_valid  input  WAYS  per-way valid bits for req_set.
REQ-012 SHALL have port out_valid  output  1  result present.
REQ-013 SHALL have port out_ready  input  1  downstream accepts result.
REQ-014 SHALL have port out_way  output  WAYS  one-hot selected way; feeds the downstream way encoder.
REQ-015 SHALL have port out_hit  output  1  1 = tag hit, 0 = miss/fill.
REQ-016 SHALL have port out_multi  output  1  more than one valid way matched.
REQ-017 SHALL have port out_set  output  $clog2(SETS)  set index of the result.

Function
REQ-018 SHALL compute match[i] = way_valid[i] AND (way_tags way i == req_tag), combinationally.
REQ-019 SHALL assert req_ready = !out_valid OR out_ready; accept occurs when req_valid AND req_ready.
REQ-020 SHALL, on accept, register the result into out_* the next rising edge: latency exactly 1 cycle.
REQ-021 SHALL, on accept with any match, drive out_way = lowest-index matching way, out_hit = 1.
REQ-022 SHALL set out_multi = 1 when popcount(match) >= 2, else 0.
REQ-023 SHALL, on miss with any way_valid bit 0, drive out_way = lowest-index invalid way, out_hit = 0.
REQ-024 SHALL, on miss with all ways valid, drive out_way = tree-PLRU victim of req_set, out_hit = 0.
REQ-025 SHALL keep WAYS-1 PLRU bits per set, node 0 = root, children of node n = 2n+1 (lower half), 2n+2 (upper half).
REQ-026 SHALL walk the victim tree: bit 0 -> lower-index subtree, bit 1 -> upper-index subtree.
REQ-027 SHALL, on every accept, update the PLRU bits of req_set on the selected way's path to point away from that way; other sets unchanged.
REQ-028 SHALL make the PLRU update visible to the next cycle's accept; back-to-back same-set requests use updated state.
REQ-029 SHALL hold out_* stable while out_valid = 1 and out_ready = 0.
REQ-030 SHALL clear out_valid when out_ready = 1 and no new accept occurs that cycle.
REQ-031 SHALL always drive out_way one-hot while out_valid = 1; value when out_valid = 0 is don't-care after reset.
REQ-032 SHALL not update PLRU state when no accept occurs.

Reset
REQ-033 SHALL, while reset = 1, clear all PLRU bits to 0 and drive out_valid = 0, out_way = 0, out_hit = 0, out_multi = 0, out_set = 0, independent of clk.
REQ-034 SHALL discard any in-flight result on reset mid-operation; no partial PLRU update survives.
REQ-035 SHALL drive req_ready = 1 during and after reset (out_valid = 0).

Verification
REQ-036 SHALL pass: after reset, set 3, way_valid = 8'hFF, no match, two accepts -> out_way = 8'h01 then 8'h10, out_hit = 0.
REQ-037 SHALL pass: way_valid = 8'hFF, way 5 tag = req_tag -> out_way = 8'h20, out_hit = 1, out_multi = 0, one cycle after accept.
REQ-038 SHALL pass: way_valid = 8'hF7, no match -> out_way = 8'h08, out_hit = 0, PLRU of set unchanged for ways other than path of way 3.
REQ-039 SHALL pass: ways 2 and 6 both match -> out_way = 8'h04, out_hit = 1, out_multi = 1.
REQ-040 SHALL pass: out_valid = 1, out_ready = 0 for 3 cycles with req_valid = 1 -> req_ready = 0, out_* unchanged; out_ready = 1 -> next request accepted same cycle.
REQ-041 SHALL pass: reset asserted one cycle after an accept -> out_valid = 0 immediately; subsequent full-set miss on that set -> out_way = 8'h01.

Source files
------------

// File: rtl/plru_way_select.sv
// Way selection for a set-associative lookup: tag hit, else first free way, else tree-PLRU victim.
// One-cycle registered result with a valid/ready output stage; per-set PLRU bits updated on every accept.
module plru_way_select #(
    parameter int WAYS  = 8,
    parameter int SETS  = 16,
    parameter int TAG_W = 12
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic [$clog2(SETS)-1:0]  req_set,
    input  logic [TAG_W-1:0]         req_tag,
    input  logic [WAYS*TAG_W-1:0]    way_tags,
    input  logic [WAYS-1:0]          way_valid,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WAYS-1:0]          out_way,
    output logic                     out_hit,
    output logic                     out_multi,
    output logic [$clog2(SETS)-1:0]  out_set
);

    localparam int LW = $clog2(WAYS);
    // Index width for the WAYS-1 tree nodes of one set.
    localparam int NW = (WAYS > 2) ? $clog2(WAYS - 1) : 1;

    logic [WAYS-2:0] plru_q [SETS];
    logic [WAYS-2:0] plru_row;
    logic [WAYS-2:0] plru_row_next;

    logic [WAYS-1:0] match;
    logic [LW-1:0]   hit_idx;
    logic [LW-1:0]   inv_idx;
    logic [LW-1:0]   victim_idx;
    logic [LW-1:0]   sel_idx;
    logic            any_hit;
    logic            any_inv;
    logic            multi;
    logic            accept;

    assign req_ready = !out_valid || out_ready;
    assign accept    = req_valid && req_ready;
    assign plru_row  = plru_q[req_set];

    always_comb begin
        for (int i = 0; i < WAYS; i++) begin
            match[i] = way_valid[i] && (way_tags[i*TAG_W +: TAG_W] == req_tag);
        end
    end

    // Scanning downwards lets the lowest index win without a separate priority encoder.
    always_comb begin
        hit_idx = '0;
        inv_idx = '0;
        any_hit = 1'b0;
        any_inv = 1'b0;
        for (int i = WAYS - 1; i >= 0; i--) begin
            if (match[i]) begin
                hit_idx = LW'(i);
                any_hit = 1'b1;
            end
            if (!way_valid[i]) begin
                inv_idx = LW'(i);
                any_inv = 1'b1;
            end
        end
        multi = ($countones(match) >= 2);
    end

    always_comb begin
        int node;
        node = 0;
        for (int lvl = 0; lvl < LW; lvl++) begin
            node = 2 * node + 1 + int'(plru_row[NW'(node)]);
        end
        victim_idx = LW'(node - (WAYS - 1));
    end

    always_comb begin
        if (any_hit) begin
            sel_idx = hit_idx;
        end else if (any_inv) begin
            sel_idx = inv_idx;
        end else begin
            sel_idx = victim_idx;
        end
    end

    // Each node on the selected way's path is pointed at the opposite subtree.
    always_comb begin
        int  node;
        logic dir;
        plru_row_next = plru_row;
        node = 0;
        for (int lvl = 0; lvl < LW; lvl++) begin
            dir = sel_idx[LW-1-lvl];
            plru_row_next[NW'(node)] = !dir;
            node = 2 * node + 1 + int'(dir);
        end
    end

    // NOTE: the PLRU array is reset as a whole so replacement order is deterministic after reset;
    // this forces flops rather than a RAM, which is acceptable at these sizes.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int s = 0; s < SETS; s++) begin
                plru_q[s] <= '0;
            end
        end else if (accept) begin
            plru_q[req_set] <= plru_row_next;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_way   <= '0;
            out_hit   <= 1'b0;
            out_multi <= 1'b0;
            out_set   <= '0;
        end else if (accept) begin
            out_valid <= 1'b1;
            out_way   <= {{(WAYS-1){1'b0}}, 1'b1} << sel_idx;
            out_hit   <= any_hit;
            out_multi <= multi;
            out_set   <= req_set;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_plru_way_select.sv
// Self-checking bench for plru_way_select: directed vectors, stall/reset sequences, and random
// traffic compared against a recency-timestamp model of tree-PLRU replacement.
module tb_plru_way_select;

    localparam int WAYS  = 8;
    localparam int SETS  = 16;
    localparam int TAG_W = 12;

    logic                    clk;
    logic                    reset;
    logic                    req_valid;
    logic                    req_ready;
    logic [3:0]              req_set;
    logic [TAG_W-1:0]        req_tag;
    logic [WAYS*TAG_W-1:0]   way_tags;
    logic [WAYS-1:0]         way_valid;
    logic                    out_valid;
    logic                    out_ready;
    logic [WAYS-1:0]         out_way;
    logic                    out_hit;
    logic                    out_multi;
    logic [3:0]              out_set;

    plru_way_select #(.WAYS(WAYS), .SETS(SETS), .TAG_W(TAG_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_set   (req_set),
        .req_tag   (req_tag),
        .way_tags  (way_tags),
        .way_valid (way_valid),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_way   (out_way),
        .out_hit   (out_hit),
        .out_multi (out_multi),
        .out_set   (out_set)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Model state: time of last access per way (0 = never since reset).
    int unsigned ts [SETS][WAYS];
    int unsigned now_t;
    logic [7:0]  m_way;
    logic        m_hit;
    logic        m_multi;

    typedef struct {
        logic [3:0]   set;
        logic [11:0]  tag;
        logic [95:0]  tags;
        logic [7:0]   vld;
        logic [7:0]   exp_way;
        logic         exp_hit;
        logic         exp_multi;
    } vec_t;

    vec_t vecs [9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [95:0] mk_tags(input logic [7:0] hit_mask, input logic [11:0] t);
        logic [95:0] r;
        for (int i = 0; i < WAYS; i++) begin
            r[i*12 +: 12] = hit_mask[i] ? t : 12'(12'h100 + i);
        end
        return r;
    endfunction

    function automatic void model_clear();
        for (int s = 0; s < SETS; s++)
            for (int w = 0; w < WAYS; w++)
                ts[s][w] = 0;
        now_t = 0;
    endfunction

    function automatic int unsigned max_ts(input int s, input int lo, input int hi);
        int unsigned m = 0;
        for (int w = lo; w < hi; w++)
            if (ts[s][w] > m) m = ts[s][w];
        return m;
    endfunction

    // Tree PLRU walks toward the half whose most recent access is older.
    function automatic int victim(input int s);
        int lo = 0;
        int hi = WAYS;
        while (hi - lo > 1) begin
            int mid = (lo + hi) / 2;
            int unsigned ml = max_ts(s, lo, mid);
            int unsigned mh = max_ts(s, mid, hi);
            if (ml > mh) lo = mid;
            else         hi = mid;
        end
        return lo;
    endfunction

    function automatic void model_step(input int s, input logic [11:0] t,
                                       input logic [95:0] tg, input logic [7:0] v);
        int nm = 0;
        int first_hit = -1;
        int first_inv = -1;
        int w;
        for (int i = 0; i < WAYS; i++) begin
            if (v[i] && tg[i*12 +: 12] == t) begin
                nm++;
                if (first_hit < 0) first_hit = i;
            end
            if (!v[i] && first_inv < 0) first_inv = i;
        end
        if (first_hit >= 0)      w = first_hit;
        else if (first_inv >= 0) w = first_inv;
        else                     w = victim(s);
        m_way   = 8'd1 << w;
        m_hit   = (first_hit >= 0);
        m_multi = (nm >= 2);
        now_t++;
        ts[s][w] = now_t;
    endfunction

    // Drives one request with out_ready high; returns #1 after the accepting edge.
    task automatic send(input logic [3:0] s, input logic [11:0] t,
                        input logic [95:0] tg, input logic [7:0] v);
        @(negedge clk);
        req_set   = s;
        req_tag   = t;
        way_tags  = tg;
        way_valid = v;
        req_valid = 1'b1;
        out_ready = 1'b1;
        model_step(s, t, tg, v);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic check_out(input string name, input logic [3:0] s, input logic [7:0] w,
                             input logic h, input logic m);
        check({name, ".valid"}, 32'(out_valid), 32'd1);
        check({name, ".way"},   32'(out_way),   32'(w));
        check({name, ".hit"},   32'(out_hit),   32'(h));
        check({name, ".multi"}, 32'(out_multi), 32'(m));
        check({name, ".set"},   32'(out_set),   32'(s));
    endtask

    initial begin
        logic [95:0] base;
        base = mk_tags(8'h00, 12'h0AA);

        vecs[0] = '{4'd3,  12'h0AA, base,                    8'hFF, 8'h01, 1'b0, 1'b0};
        vecs[1] = '{4'd3,  12'h0AA, base,                    8'hFF, 8'h10, 1'b0, 1'b0};
        vecs[2] = '{4'd3,  12'h0AA, mk_tags(8'h20, 12'h0AA), 8'hFF, 8'h20, 1'b1, 1'b0};
        vecs[3] = '{4'd7,  12'h0AA, base,                    8'hF7, 8'h08, 1'b0, 1'b0};
        vecs[4] = '{4'd7,  12'h0AA, mk_tags(8'h44, 12'h0AA), 8'hFF, 8'h04, 1'b1, 1'b1};
        vecs[5] = '{4'd7,  12'h0AA, mk_tags(8'h44, 12'h0AA), 8'hFB, 8'h40, 1'b1, 1'b0};
        vecs[6] = '{4'd0,  12'h0AA, base,                    8'h00, 8'h01, 1'b0, 1'b0};
        vecs[7] = '{4'd3,  12'h0AA, base,                    8'hFF, 8'h04, 1'b0, 1'b0};
        vecs[8] = '{4'd15, 12'h3C5, mk_tags(8'h80, 12'h3C5), 8'hFF, 8'h80, 1'b1, 1'b0};

        reset     = 1'b1;
        req_valid = 1'b0;
        out_ready = 1'b0;
        req_set   = '0;
        req_tag   = '0;
        way_tags  = '0;
        way_valid = '0;
        model_clear();
        #1;
        check("rst.valid", 32'(out_valid), 32'd0);
        check("rst.way",   32'(out_way),   32'd0);
        check("rst.hit",   32'(out_hit),   32'd0);
        check("rst.multi", 32'(out_multi), 32'd0);
        check("rst.set",   32'(out_set),   32'd0);
        check("rst.ready", 32'(req_ready), 32'd1);
        repeat (2) @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 9; i++) begin
            send(vecs[i].set, vecs[i].tag, vecs[i].tags, vecs[i].vld);
            check_out($sformatf("vec%0d", i), vecs[i].set, vecs[i].exp_way,
                      vecs[i].exp_hit, vecs[i].exp_multi);
        end
        @(posedge clk);
        #1;
        check("idle.valid_clear", 32'(out_valid), 32'd0);

        // Back-pressure: result held for three cycles, then the waiting request goes through.
        @(negedge clk);
        req_set   = 4'd5;
        req_tag   = 12'h0AA;
        way_tags  = base;
        way_valid = 8'hFF;
        req_valid = 1'b1;
        out_ready = 1'b0;
        model_step(5, 12'h0AA, base, 8'hFF);
        @(posedge clk);
        #1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check($sformatf("stall%0d.ready", c), 32'(req_ready), 32'd0);
            check_out($sformatf("stall%0d", c), 4'd5, 8'h01, 1'b0, 1'b0);
        end
        out_ready = 1'b1;
        #1;
        check("stall.release_ready", 32'(req_ready), 32'd1);
        model_step(5, 12'h0AA, base, 8'hFF);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        check_out("stall.next", 4'd5, 8'h10, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        check("stall.drain", 32'(out_valid), 32'd0);

        // Reset right after an accept drops the result and the PLRU history.
        send(4'd9, 12'h0AA, base, 8'hFF);
        check_out("prerst", 4'd9, 8'h01, 1'b0, 1'b0);
        @(negedge clk);
        out_ready = 1'b0;
        reset     = 1'b1;
        #1;
        check("midrst.valid", 32'(out_valid), 32'd0);
        check("midrst.way",   32'(out_way),   32'd0);
        check("midrst.ready", 32'(req_ready), 32'd1);
        model_clear();
        @(negedge clk);
        reset = 1'b0;
        send(4'd9, 12'h0AA, base, 8'hFF);
        check_out("postrst9", 4'd9, 8'h01, 1'b0, 1'b0);
        send(4'd3, 12'h0AA, base, 8'hFF);
        check_out("postrst3", 4'd3, 8'h01, 1'b0, 1'b0);

        for (int n = 0; n < 400; n++) begin
            logic [3:0]  s;
            logic [11:0] t;
            logic [95:0] tg;
            logic [7:0]  v;
            s = 4'($urandom_range(0, 3));
            t = 12'($urandom_range(0, 7));
            for (int i = 0; i < WAYS; i++) tg[i*12 +: 12] = 12'($urandom_range(0, 7));
            v = ($urandom_range(0, 3) != 0) ? 8'hFF : 8'($urandom);
            send(s, t, tg, v);
            check_out($sformatf("rnd%0d", n), s, m_way, m_hit, m_multi);
            if ($urandom_range(0, 4) == 0) begin
                @(posedge clk);
                #1;
                check($sformatf("rnd%0d.idle", n), 32'(out_valid), 32'd0);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
